// File: rtl/vga_axi_rd_arbiter.sv
// vga_axi_rd_arbiter: shares one AXI4-Lite read port between the VGA prefetch path (r0)
// and a secondary reader (r1). One transaction is outstanding at a time, and r1 has a starvation override.
module vga_axi_rd_arbiter #(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          MAX_WAIT       = 16,
    parameter logic [2:0]  ARPROT         = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      r0_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] r0_addr_i,
    output logic                      r0_gnt_o,
    output logic                      r0_rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0] r0_rdata_o,
    output logic                      r0_rerr_o,
    input  logic                      r1_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] r1_addr_i,
    output logic                      r1_gnt_o,
    output logic                      r1_rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0] r1_rdata_o,
    output logic                      r1_rerr_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
    output logic [2:0]                m_arprot_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arrdy_i,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rrdy_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state, state_nxt;
    logic            owner;
    logic [CW-1:0]   wait_ctr, wait_nxt;
    logic            pick, pick1, ar_hs, r_hs;

    assign m_arprot_o = ARPROT;

    always_comb begin
        pick  = (state == IDLE) && (r0_req_i || r1_req_i);
        // A starved r1 overrides r0; otherwise r1 wins only when r0 is idle.
        pick1 = (r1_req_i && (wait_ctr >= CW'(MAX_WAIT))) || !r0_req_i;
        ar_hs = (state == ADDR) && m_arvalid_o && m_arrdy_i;
        r_hs  = (state == DATA) && m_rrdy_o && m_rvalid_i;
        wait_nxt = (!r1_req_i || (pick && pick1)) ? '0 :
                   (((state != IDLE) && owner) || (wait_ctr >= CW'(MAX_WAIT))) ? wait_ctr :
                   wait_ctr + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick  ? ADDR : IDLE;
            ADDR:    state_nxt = ar_hs ? DATA : ADDR;
            DATA:    state_nxt = r_hs  ? IDLE : DATA;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            wait_ctr    <= '0;
            m_araddr_o  <= '0;
            m_arvalid_o <= 1'b0;
            m_rrdy_o    <= 1'b0;
            r0_gnt_o    <= 1'b0;
            r1_gnt_o    <= 1'b0;
            r0_rvalid_o <= 1'b0;
            r1_rvalid_o <= 1'b0;
            r0_rdata_o  <= '0;
            r1_rdata_o  <= '0;
            r0_rerr_o   <= 1'b0;
            r1_rerr_o   <= 1'b0;
        end else begin
            wait_ctr    <= wait_nxt;
            r0_gnt_o    <= 1'b0;
            r1_gnt_o    <= 1'b0;
            r0_rvalid_o <= 1'b0;
            r1_rvalid_o <= 1'b0;
            if (pick) begin
                owner       <= pick1;
                m_araddr_o  <= pick1 ? r1_addr_i : r0_addr_i;
                m_arvalid_o <= 1'b1;
            end
            if (ar_hs) begin
                m_arvalid_o <= 1'b0;
                m_rrdy_o    <= 1'b1;
                r0_gnt_o    <= !owner;
                r1_gnt_o    <= owner;
            end
            if (r_hs) begin
                m_rrdy_o <= 1'b0;
                if (owner) begin
                    r1_rvalid_o <= 1'b1;
                    r1_rdata_o  <= m_rdata_i;
                    r1_rerr_o   <= (m_rresp_i != 2'b00);
                end else begin
                    r0_rvalid_o <= 1'b1;
                    r0_rdata_o  <= m_rdata_i;
                    r0_rerr_o   <= (m_rresp_i != 2'b00);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_axi_rd_arbiter.sv
// tb_vga_axi_rd_arbiter: directed vectors for single reads on either port, plus sequences
// for arbitration, starvation override, AR stall, spurious R beats and mid-transaction reset.
module tb_vga_axi_rd_arbiter;
    localparam int         AW   = 32;
    localparam int         DW   = 64;
    localparam int         MW   = 4;
    localparam logic [2:0] PROT = 3'b010;

    logic          clk = 0, rst_n = 0;
    logic          r0_req_i = 0, r1_req_i = 0;
    logic [AW-1:0] r0_addr_i = '0, r1_addr_i = '0;
    logic          r0_gnt_o, r0_rvalid_o, r0_rerr_o, r1_gnt_o, r1_rvalid_o, r1_rerr_o;
    logic [DW-1:0] r0_rdata_o, r1_rdata_o;
    logic [AW-1:0] m_araddr_o;
    logic [2:0]    m_arprot_o;
    logic          m_arvalid_o, m_rrdy_o;
    logic          m_arrdy_i = 0, m_rvalid_i = 0;
    logic [DW-1:0] m_rdata_i = '0;
    logic [1:0]    m_rresp_i = '0;

    always #5 clk = ~clk;

    vga_axi_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MAX_WAIT(MW), .ARPROT(PROT)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o),
        .r0_rdata_o(r0_rdata_o), .r0_rerr_o(r0_rerr_o),
        .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o),
        .r1_rdata_o(r1_rdata_o), .r1_rerr_o(r1_rerr_o),
        .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o), .m_arvalid_o(m_arvalid_o), .m_arrdy_i(m_arrdy_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rrdy_o(m_rrdy_o)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Bus slave: AR ready after ar_delay stalled cycles, R beat as soon as R ready is seen.
    int            ar_delay = 0, stall = 0;
    logic [DW-1:0] s_data = '0;
    logic [1:0]    s_resp = '0;
    bit            hold_r = 0, r_always = 0;
    logic [AW-1:0] seen_addr = '0;

    always @(negedge clk) begin
        if (m_arvalid_o && !m_arrdy_i) begin
            if (stall < ar_delay) stall++;
            else begin m_arrdy_i = 1; seen_addr = m_araddr_o; end
        end else begin
            m_arrdy_i = 0;
            stall = 0;
        end
        m_rvalid_i = r_always || (m_rrdy_o && !hold_r);
        m_rdata_i  = s_data;
        m_rresp_i  = s_resp;
    end

    int            gcnt0 = 0, gcnt1 = 0, rcnt0 = 0, rcnt1 = 0, arv_cycles = 0;
    bit            addr_chg = 0;
    logic [AW-1:0] first_addr = '0;
    int            order[$];

    always @(negedge clk) begin
        if (r0_gnt_o) begin gcnt0++; order.push_back(0); end
        if (r1_gnt_o) begin gcnt1++; order.push_back(1); end
        if (r0_rvalid_o) rcnt0++;
        if (r1_rvalid_o) rcnt1++;
        if (m_arvalid_o) begin
            if (arv_cycles == 0) first_addr = m_araddr_o;
            else if (m_araddr_o !== first_addr) addr_chg = 1;
            arv_cycles++;
        end
    end

    typedef struct {
        bit            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            delay;
        bit            err;
    } vec_t;

    vec_t          vecs[7];
    logic [DW-1:0] last_data[2];
    bit            last_err[2];

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {r0_gnt_o, r0_rvalid_o, r0_rerr_o, r1_gnt_o, r1_rvalid_o, r1_rerr_o, m_arvalid_o, m_rrdy_o}, 0);
        chk({tag, "_rdata"}, {r0_rdata_o, r1_rdata_o}, 0);
        chk({tag, "_araddr"}, m_araddr_o, 0);
        chk({tag, "_arprot"}, m_arprot_o, PROT);
    endtask

    task automatic read(input bit port, input logic [AW-1:0] addr, output bit ok);
        int gb = port ? gcnt1 : gcnt0;
        int rb = port ? rcnt1 : rcnt0;
        int n = 0;
        if (port) begin r1_req_i = 1; r1_addr_i = addr; end
        else      begin r0_req_i = 1; r0_addr_i = addr; end
        tick();
        // Address moves after selection; the latched one must still go out.
        if (port) r1_addr_i = ~addr; else r0_addr_i = ~addr;
        while (n < 50 && (port ? gcnt1 : gcnt0) == gb) begin tick(); n++; end
        if (port) r1_req_i = 0; else r0_req_i = 0;
        while (n < 100 && (port ? rcnt1 : rcnt0) == rb) begin tick(); n++; end
        ok = (port ? rcnt1 : rcnt0) != rb;
    endtask

    task automatic run_vec(input vec_t v);
        int g0 = gcnt0, g1 = gcnt1, q0 = rcnt0, q1 = rcnt1;
        bit ok;
        arv_cycles = 0; addr_chg = 0;
        ar_delay = v.delay; s_data = v.data; s_resp = v.resp;
        read(v.port, v.addr, ok);
        chk("done", ok, 1);
        chk("gnt_own",   v.port ? gcnt1 - g1 : gcnt0 - g0, 1);
        chk("gnt_other", v.port ? gcnt0 - g0 : gcnt1 - g1, 0);
        chk("rv_own",    v.port ? rcnt1 - q1 : rcnt0 - q0, 1);
        chk("rv_other",  v.port ? rcnt0 - q0 : rcnt1 - q1, 0);
        chk("rdata",     v.port ? r1_rdata_o : r0_rdata_o, v.data);
        chk("rerr",      v.port ? r1_rerr_o : r0_rerr_o, v.err);
        chk("rdata_hold", v.port ? r0_rdata_o : r1_rdata_o, last_data[!v.port]);
        chk("rerr_hold",  v.port ? r0_rerr_o : r1_rerr_o, last_err[!v.port]);
        chk("araddr",     seen_addr, v.addr);
        chk("arv_cycles", arv_cycles, v.delay + 1);
        chk("addr_stable", addr_chg, 0);
        last_data[v.port] = v.data;
        last_err[v.port]  = v.err;
    endtask

    task automatic serve(input int want, input bit r0_hold);
        int g0 = gcnt0, g1 = gcnt1;
        for (int n = 0; n < 200 && order.size() < want; n++) begin
            tick();
            if (gcnt1 != g1) r1_req_i = 0;
            if (gcnt0 != g0 && !r0_hold) r0_req_i = 0;
        end
        r0_req_i = 0;
        r1_req_i = 0;
        tick(6);
    endtask

    initial begin
        int q0, q1, n;
        vecs[0] = '{0, 32'h0000_0100, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 0, 0};
        vecs[1] = '{1, 32'h0000_2000, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 1};
        vecs[2] = '{0, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 2, 1};
        vecs[3] = '{1, 32'h0000_0000, 64'h0000_0000_0000_0000, 2'b01, 1, 1};
        vecs[4] = '{0, 32'h0BAD_F00C, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 5, 0};
        vecs[5] = '{1, 32'h0000_0010, 64'h1111_2222_3333_4444, 2'b00, 0, 0};
        vecs[6] = '{0, 32'h0000_0200, 64'h5A5A_0000_FFFF_1234, 2'b00, 0, 0};
        last_data[0] = '0; last_data[1] = '0; last_err[0] = 0; last_err[1] = 0;

        #3 chk_quiet("reset");
        tick(2);
        rst_n = 1;
        tick(2);
        chk_quiet("post_reset");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Simultaneous requests: r0 first, r1 in the following IDLE.
        order.delete();
        ar_delay = 0; s_resp = 2'b00; s_data = 64'h0F0F_0F0F_0F0F_0F0F;
        r0_req_i = 1; r0_addr_i = 32'h300; r1_req_i = 1; r1_addr_i = 32'h400;
        serve(2, 0);
        chk("simul_count", order.size(), 2);
        if (order.size() == 2) begin
            chk("simul_first", order[0], 0);
            chk("simul_second", order[1], 1);
        end
        chk("simul_r1_data", r1_rdata_o, 64'h0F0F_0F0F_0F0F_0F0F);
        last_data[0] = s_data; last_data[1] = s_data; last_err[0] = 0; last_err[1] = 0;

        // r0 never lets go: r1 must break in once its wait reaches MAX_WAIT.
        order.delete();
        r0_req_i = 1; r0_addr_i = 32'h40; r1_req_i = 1; r1_addr_i = 32'h80;
        serve(4, 1);
        chk("starve_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("starve_0", order[0], 0);
            chk("starve_1", order[1], 0);
            chk("starve_2", order[2], 1);
            chk("starve_3", order[3], 0);
        end

        // R beats while idle must be ignored.
        q0 = rcnt0; q1 = rcnt1;
        r_always = 1;
        tick(5);
        r_always = 0;
        chk("spurious_rv", (rcnt0 - q0) + (rcnt1 - q1), 0);
        chk("spurious_rrdy", m_rrdy_o, 0);
        tick(2);

        // Reset while waiting in DATA.
        hold_r = 1; ar_delay = 0;
        r0_req_i = 1; r0_addr_i = 32'h500;
        n = 0;
        while (n < 50 && !m_rrdy_o) begin tick(); n++; end
        chk("reach_data", m_rrdy_o, 1);
        r0_req_i = 0;
        #2 rst_n = 0;
        #1 chk_quiet("async_reset");
        hold_r = 0;
        tick(2);
        rst_n = 1;
        tick(2);
        chk_quiet("after_reset");
        last_data[0] = '0; last_data[1] = '0; last_err[0] = 0; last_err[1] = 0;
        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
